// File: rtl/frame_write_sequencer.sv
// Frame-buffer write bus master: once per frame it grants the shared bus to each draw
// source in ID order and turns accepted pixels into registered RAM writes. Optional request watchdog: SEQ_TIMEOUT_EN.
module frame_write_sequencer #(
    parameter int NUM_SOURCES       = 4,
    parameter int SOURCE_SEL_ADDRW  = 3,
    parameter int COLOR_DEPTH       = 8,
    parameter int DRAW_WIDTH        = 160,
    parameter int DRAW_HEIGHT       = 120,
    parameter int DRAW_WIDTH_ADDRW  = 8,
    parameter int DRAW_HEIGHT_ADDRW = 7,
    parameter int FB_ADDRW          = 15,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [FB_ADDRW-1:0]          fb_addr,
    output logic [COLOR_DEPTH-1:0]       fb_wdata,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_overrun,
    output logic [NUM_SOURCES-1:0]       source_timeout
);

    // state  | meaning
    // IDLE   | waiting for frame_start
    // SELECT | source select settles on the bus, no request
    // AWAIT  | request raised, waiting for the source to start
    // ACTIVE | accepting one pixel per cycle while write_active
    // NEXT   | advance to the next source or finish
    // DONE   | one-cycle frame_done, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_AWAIT, S_ACTIVE, S_NEXT, S_DONE
    } state_t;

    generate
        if ((2**SOURCE_SEL_ADDRW < NUM_SOURCES) ||
            (FB_ADDRW < $clog2(DRAW_WIDTH*DRAW_HEIGHT)) ||
            (TIMEOUT_CYCLES < 1)) begin : g_bad_params
            $error("frame_write_sequencer: illegal parameter set");
        end
    endgenerate

    state_t                      state;
    state_t                      state_nxt;
    logic [SOURCE_SEL_ADDRW-1:0] sel;
    logic                        last_src;
    logic                        accept;
    logic                        timeout_hit;
    logic                        in_range;
    logic                        pix_we;
    logic [FB_ADDRW-1:0]         addr_calc;

    assign last_src         = (sel == SOURCE_SEL_ADDRW'(NUM_SOURCES-1));
    assign write_source_sel = sel;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0]       tmr;
    logic [NUM_SOURCES-1:0] to_flags;

    // Down-counter loaded while the select settles, so it starts fresh on AWAIT entry.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tmr <= '0;
        end else if (state == S_SELECT) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES-1);
        end else if ((state == S_AWAIT) && (tmr != '0)) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    assign timeout_hit = (state == S_AWAIT) && !write_active && (tmr == '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            to_flags <= '0;
        end else if ((state == S_IDLE) && frame_start) begin
            to_flags <= '0;
        end else if (timeout_hit) begin
            to_flags <= to_flags | (NUM_SOURCES'(1) << sel);
        end
    end

    assign source_timeout = to_flags;
`else
    assign timeout_hit    = 1'b0;
    assign source_timeout = '0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_start) state_nxt = S_SELECT;
            S_SELECT: state_nxt = S_AWAIT;
            S_AWAIT: begin
                if (write_active)     state_nxt = S_ACTIVE;
                else if (timeout_hit) state_nxt = S_NEXT;
            end
            S_ACTIVE: if (!write_active) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = last_src ? S_DONE : S_SELECT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The request drops combinationally the cycle the source answers.
    always_comb begin
        write_awaited = 1'b0;
        accept        = 1'b0;
        frame_done    = 1'b0;
        busy          = (state != S_IDLE);
        frame_overrun = frame_start && (state != S_IDLE);
        case (state)
            S_AWAIT: begin
                write_awaited = !write_active && !timeout_hit;
                accept        = write_active;
            end
            S_ACTIVE: accept     = write_active;
            S_DONE:   frame_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sel <= '0;
        end else if ((state == S_IDLE) && frame_start) begin
            sel <= '0;
        end else if ((state == S_NEXT) && !last_src) begin
            sel <= sel + SOURCE_SEL_ADDRW'(1);
        end else if (state == S_DONE) begin
            sel <= '0;
        end
    end

    assign in_range  = (32'(write_x_addr) < DRAW_WIDTH) && (32'(write_y_addr) < DRAW_HEIGHT);
    assign addr_calc = FB_ADDRW'(write_y_addr) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(write_x_addr);
    assign pix_we    = accept && !write_transparent && in_range;

    // Address and data only move on a real write so the RAM port sees stable values otherwise.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else begin
            fb_we <= pix_we;
            if (pix_we) begin
                fb_addr  <= addr_calc;
                fb_wdata <= write_color_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Self-checking bench for frame_write_sequencer; the watchdog frames run only when SEQ_TIMEOUT_EN is defined.
module tb_frame_write_sequencer;

    localparam int NS = 4;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frame_start = 1'b0;
    logic       write_active = 1'b0;
    logic       write_transparent = 1'b0;
    logic [7:0] write_color_data = '0;
    logic [7:0] write_x_addr = '0;
    logic [6:0] write_y_addr = '0;
    logic [2:0] write_source_sel;
    logic       write_awaited;
    logic       fb_we;
    logic [14:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       busy;
    logic       frame_done;
    logic       frame_overrun;
    logic [NS-1:0] source_timeout;

    frame_write_sequencer #(
        .NUM_SOURCES(NS), .SOURCE_SEL_ADDRW(3), .COLOR_DEPTH(8),
        .DRAW_WIDTH(W), .DRAW_HEIGHT(H), .DRAW_WIDTH_ADDRW(8),
        .DRAW_HEIGHT_ADDRW(7), .FB_ADDRW(15), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start),
        .write_source_sel(write_source_sel), .write_awaited(write_awaited),
        .write_active(write_active), .write_color_data(write_color_data),
        .write_transparent(write_transparent), .write_x_addr(write_x_addr),
        .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .busy(busy), .frame_done(frame_done),
        .frame_overrun(frame_overrun), .source_timeout(source_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {int src; int x; int y; int c; bit t;} pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t pix_q[$];
    int   got_addr[$];
    int   got_data[$];
    int   aw_sel[$];
    int   done_cnt = 0;
    int   ovr_cnt = 0;
    int   hs_err = 0;
    logic aw_prev = 1'b0;

    always @(negedge clk) begin
        if (fb_we) begin
            got_addr.push_back(int'(fb_addr));
            got_data.push_back(int'(fb_wdata));
        end
        if (write_awaited && !aw_prev) aw_sel.push_back(int'(write_source_sel));
        if (write_awaited && write_active) hs_err++;
        if (frame_done) done_cnt++;
        if (frame_overrun) ovr_cnt++;
        aw_prev = write_awaited;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pix(input int src, input int x, input int y, input int c, input bit t);
        pix_t p;
        p.src = src; p.x = x; p.y = y; p.c = c; p.t = t;
        pix_q.push_back(p);
    endtask

    task automatic add_random(input int src, input int n, input bit wild);
        for (int i = 0; i < n; i++)
            add_pix(src, $urandom_range(0, wild ? 255 : W-1), $urandom_range(0, wild ? 127 : H-1),
                    $urandom_range(0, 255), wild ? ($urandom_range(0, 3) == 0) : 1'b0);
    endtask

    task automatic start_frame();
        got_addr.delete(); got_data.delete(); aw_sel.delete();
        done_cnt = 0; ovr_cnt = 0; hs_err = 0;
        frame_start = 1'b1;
        #1;
        chk("overrun_in_idle", frame_overrun, 0);
        tick();
        frame_start = 1'b0;
    endtask

    // Behavioural source: answers the request after dly cycles and streams its pixels.
    task automatic serve(input int id, input int dly, input int ovr_at);
        int   prev_sel = -1;
        logic prev_aw = 1'b1;
        bit   seen = 0;
        int   n = 0;
        int   i = 0;
        int   cnt = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (write_awaited) seen = 1;
            else begin
                prev_sel = int'(write_source_sel);
                prev_aw = write_awaited;
                tick();
            end
        end
        chk("request_seen", seen, 1);
        if (!seen) return;
        chk("settle_sel", prev_sel, id);
        chk("settle_no_request", prev_aw, 0);
        chk("sel_in_await", write_source_sel, id);
        foreach (pix_q[j]) if (pix_q[j].src == id) n++;
        if (n == 0) begin
            for (int k = 0; k < TO + 4 && write_awaited; k++) begin
                tick();
                cnt++;
            end
            chk("timeout_window", (cnt >= TO - 1) && (cnt <= TO + 1), 1);
            tick();
            chk("timeout_flag", source_timeout[id], 1);
            return;
        end
        for (int d = 0; d < dly; d++) tick();
        chk("request_held", write_awaited, 1);
        foreach (pix_q[j]) begin
            if (pix_q[j].src == id) begin
                write_active = 1'b1;
                write_x_addr = 8'(pix_q[j].x);
                write_y_addr = 7'(pix_q[j].y);
                write_color_data = 8'(pix_q[j].c);
                write_transparent = pix_q[j].t;
                if (i == ovr_at) frame_start = 1'b1;
                #1;
                if (i == 0) chk("request_drop", write_awaited, 0);
                if (i == ovr_at) chk("overrun_mid", frame_overrun, 1);
                tick();
                frame_start = 1'b0;
                i++;
            end
        end
        write_active = 1'b0;
        write_transparent = 1'b0;
    endtask

    task automatic finish_frame(input bit ovr_done);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (frame_done) seen = 1;
            else tick();
        end
        chk("done_seen", seen, 1);
        chk("busy_in_done", busy, 1);
        if (ovr_done) begin
            frame_start = 1'b1;
            #1;
            chk("overrun_on_done", frame_overrun, 1);
        end
        tick();
        frame_start = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_single", frame_done, 0);
        tick();
        tick();
        chk("no_restart", busy, 0);
    endtask

    // Reference: painter's-order write list from the pixel table and the write rules.
    task automatic check_frame(input int exp_ovr, input int exp_to);
        int ea[$];
        int ed[$];
        int bad = 0;
        int sbad = 0;
        foreach (pix_q[j])
            if (!pix_q[j].t && pix_q[j].x < W && pix_q[j].y < H) begin
                ea.push_back(pix_q[j].y * W + pix_q[j].x);
                ed.push_back(pix_q[j].c);
            end
        chk("write_count", got_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < got_addr.size(); i++)
            if (got_addr[i] != ea[i] || got_data[i] != ed[i]) bad++;
        chk("write_mismatches", bad, 0);
        chk("request_count", aw_sel.size(), NS);
        for (int i = 0; i < aw_sel.size(); i++) if (aw_sel[i] != i) sbad++;
        chk("request_order", sbad, 0);
        chk("done_pulses", done_cnt, 1);
        chk("overrun_pulses", ovr_cnt, exp_ovr);
        chk("handshake_overlap", hs_err, 0);
        chk("source_timeout", source_timeout, exp_to);
    endtask

    initial begin
        tick();
        chk("rst_sel", write_source_sel, 0);
        chk("rst_awaited", write_awaited, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_timeout", source_timeout, 0);
        resetN = 1'b1;
        tick();

        // Single opaque pixel, other sources contribute only skipped pixels.
        pix_q.delete();
        add_pix(0, 3, 2, 'h5A, 0);
        add_pix(1, 10, 10, 'h11, 1);
        add_pix(2, 5, 5, 'h22, 1);
        add_pix(3, 200, 1, 'h33, 0);
        start_frame();
        for (int s = 0; s < NS; s++) serve(s, 2 + s, -1);
        finish_frame(0);
        check_frame(0, 0);
        chk("single_addr", fb_addr, 323);
        chk("single_data", fb_wdata, 'h5A);

        // Full opaque background then random mixed pixels on top.
        pix_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) add_pix(0, x, y, 'h92, 0);
        for (int s = 1; s < NS; s++) add_random(s, 25, 1);
        start_frame();
        for (int s = 0; s < NS; s++) serve(s, $urandom_range(2, 6), -1);
        finish_frame(0);
        check_frame(0, 0);
        if (got_addr.size() >= W*H) chk("bg_last_addr", got_addr[W*H-1], W*H-1);

        // Overrun mid-pass and on the DONE cycle.
        pix_q.delete();
        for (int s = 0; s < NS; s++) add_random(s, $urandom_range(1, 30), 1);
        start_frame();
        for (int s = 0; s < NS; s++) serve(s, $urandom_range(2, 8), (s == 1) ? 0 : -1);
        finish_frame(1);
        check_frame(2, 0);

`ifdef SEQ_TIMEOUT_EN
        pix_q.delete();
        add_random(0, 5, 0);
        add_random(2, 5, 0);
        add_random(3, 5, 0);
        start_frame();
        for (int s = 0; s < NS; s++) serve(s, 3, -1);
        finish_frame(0);
        check_frame(0, 'b0010);
        pix_q.delete();
        for (int s = 0; s < NS; s++) add_random(s, 3, 1);
        start_frame();
        chk("timeout_cleared", source_timeout, 0);
        for (int s = 0; s < NS; s++) serve(s, 2, -1);
        finish_frame(0);
        check_frame(0, 0);
`endif

        // Reset asserted while a source is streaming.
        pix_q.delete();
        start_frame();
        for (int k = 0; k < 10 && !write_awaited; k++) tick();
        tick();
        tick();
        write_active = 1'b1;
        write_x_addr = 8'd5;
        write_y_addr = 7'd5;
        write_color_data = 8'h77;
        tick();
        tick();
        chk("pre_reset_we", fb_we, 1);
        resetN = 1'b0;
        #1;
        chk("mid_rst_sel", write_source_sel, 0);
        chk("mid_rst_awaited", write_awaited, 0);
        chk("mid_rst_fb_we", fb_we, 0);
        chk("mid_rst_fb_addr", fb_addr, 0);
        chk("mid_rst_fb_wdata", fb_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", frame_overrun, 0);
        write_active = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", busy, 0);

        // Recovery pass after the abandoned one.
        pix_q.delete();
        for (int s = 0; s < NS; s++) add_random(s, 4, 1);
        start_frame();
        for (int s = 0; s < NS; s++) serve(s, 2, -1);
        finish_frame(0);
        check_frame(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
